// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between execute/memory result producers, decode, and the arbiter.
// The arbiter takes the slave side. Producers and decode take the master side.
interface regfile_wb_arbiter_if #(
    parameter int Data_width = 32,
    parameter int Addr_width = 5
);
    logic                       alu_valid;
    logic [Addr_width-1:0]      alu_rd;
    logic [Data_width-1:0]      alu_data;
    logic                       lsu_valid;
    logic                       lsu_ready;
    logic [Addr_width-1:0]      lsu_rd;
    logic [Data_width-1:0]      lsu_data;
    logic                       issue_valid;
    logic [Addr_width-1:0]      issue_rd;
    logic [Addr_width-1:0]      rs1;
    logic [Addr_width-1:0]      rs2;
    logic                       stall;
    logic [2**Addr_width-1:0]   busy;
    logic                       we3;
    logic [Addr_width-1:0]      ad3;
    logic [Data_width-1:0]      wd3;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1, rs2,
        input  lsu_ready, stall, busy, we3, ad3, wd3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1, rs2,
        output lsu_ready, stall, busy, we3, ad3, wd3
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: ALU results have priority, LSU results queue in a FIFO.
// Optional pending-write scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int Data_width = 32,
    parameter int Addr_width = 5,
    parameter int Fifo_depth = 4
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave wb
);
    localparam int Ptr_width = $clog2(Fifo_depth);
    localparam int Cnt_width = Ptr_width + 1;
    localparam int Num_regs  = 2 ** Addr_width;

    logic [Addr_width-1:0] fifo_rd_q   [Fifo_depth];
    logic [Addr_width-1:0] fifo_rd_d   [Fifo_depth];
    logic [Data_width-1:0] fifo_data_q [Fifo_depth];
    logic [Data_width-1:0] fifo_data_d [Fifo_depth];
    logic [Ptr_width-1:0]  wr_ptr_q, wr_ptr_d;
    logic [Ptr_width-1:0]  rd_ptr_q, rd_ptr_d;
    logic [Cnt_width-1:0]  count_q, count_d;
    logic                  we3_q, we3_d;
    logic [Addr_width-1:0] ad3_q, ad3_d;
    logic [Data_width-1:0] wd3_q, wd3_d;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  alu_wr;
    logic [Addr_width-1:0] head_rd;
    logic [Data_width-1:0] head_data;

    // Full is taken from the registered count, so a same-cycle pop never frees a slot early
    assign full         = (count_q == Cnt_width'(Fifo_depth));
    assign wb.lsu_ready = !rst && !full;
    assign push         = wb.lsu_valid && wb.lsu_ready;
    assign alu_wr       = wb.alu_valid && (wb.alu_rd != '0);
    assign pop          = !alu_wr && (count_q != '0);
    assign head_rd      = fifo_rd_q[rd_ptr_q];
    assign head_data    = fifo_data_q[rd_ptr_q];

    always_comb begin
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        if (push) begin
            fifo_rd_d[wr_ptr_q]   = wb.lsu_rd;
            fifo_data_d[wr_ptr_q] = wb.lsu_data;
            wr_ptr_d              = wr_ptr_q + Ptr_width'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + Ptr_width'(1);
        end
        count_d = count_q + Cnt_width'(push) - Cnt_width'(pop);
    end

    // An x0 entry still uses its pop slot, but it leaves the port idle and holds the address and data
    always_comb begin
        we3_d = 1'b0;
        ad3_d = ad3_q;
        wd3_d = wd3_q;
        if (alu_wr) begin
            we3_d = 1'b1;
            ad3_d = wb.alu_rd;
            wd3_d = wb.alu_data;
        end else if (pop && (head_rd != '0)) begin
            we3_d = 1'b1;
            ad3_d = head_rd;
            wd3_d = head_data;
        end
    end

    always_ff @(posedge clk) begin
        fifo_rd_q   <= fifo_rd_d;
        fifo_data_q <= fifo_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we3_q    <= 1'b0;
            ad3_q    <= '0;
            wd3_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we3_q    <= we3_d;
            ad3_q    <= ad3_d;
            wd3_q    <= wd3_d;
        end
    end

    assign wb.we3 = we3_q;
    assign wb.ad3 = ad3_q;
    assign wb.wd3 = wd3_q;

`ifdef WB_SCOREBOARD_EN
    logic [Num_regs-1:0] busy_q, busy_d;
    logic                lsu_src_q, lsu_src_d;
    logic                stall_int;

    assign lsu_src_d = pop;
    assign stall_int = busy_q[wb.rs1] | busy_q[wb.rs2] | (wb.issue_valid & busy_q[wb.issue_rd]);

    // Clear comes from the write currently on the port. The set is applied afterwards so that it wins on a collision.
    always_comb begin
        busy_d = busy_q;
        if (we3_q && lsu_src_q) begin
            busy_d[ad3_q] = 1'b0;
        end
        if (wb.issue_valid && !stall_int && (wb.issue_rd != '0)) begin
            busy_d[wb.issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            lsu_src_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            lsu_src_q <= lsu_src_d;
        end
    end

    assign wb.stall = stall_int;
    assign wb.busy  = busy_q;
`else
    assign wb.stall = 1'b0;
    assign wb.busy  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by random traffic,
// compared against a queue-based reference model. The expected scoreboard behaviour follows WB_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int NREG  = 2 ** AW;
`ifdef WB_SCOREBOARD_EN
    localparam logic SB = 1'b1;
`else
    localparam logic SB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.Data_width(DW), .Addr_width(AW)) wb_if ();

    regfile_wb_arbiter #(.Data_width(DW), .Addr_width(AW), .Fifo_depth(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    typedef struct packed {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } entry_t;

    int total = 0;
    int bad   = 0;

    entry_t          fifo_m[$];
    logic [NREG-1:0] busy_m;
    logic            we_m;
    logic [AW-1:0]   ad_m;
    logic [DW-1:0]   wd_m;
    logic            src_m;
    logic            x0pop_m;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic modelStall();
        if (!SB) return 1'b0;
        return busy_m[wb_if.rs1] | busy_m[wb_if.rs2] | (wb_if.issue_valid & busy_m[wb_if.issue_rd]);
    endfunction

    task automatic modelReset();
        fifo_m.delete();
        busy_m  = '0;
        we_m    = 1'b0;
        ad_m    = '0;
        wd_m    = '0;
        src_m   = 1'b0;
        x0pop_m = 1'b0;
    endtask

    // Reference behaviour at a rising edge, evaluated from the pre-edge model state and the current inputs
    task automatic modelEdge();
        entry_t h;
        logic   accept;
        logic   stall_now;
        if (rst) begin
            modelReset();
            return;
        end
        stall_now = modelStall();
        accept    = wb_if.lsu_valid && (fifo_m.size() < DEPTH);
        if (SB) begin
            if (we_m && src_m) busy_m[ad_m] = 1'b0;
            if (wb_if.issue_valid && !stall_now && wb_if.issue_rd != 0) busy_m[wb_if.issue_rd] = 1'b1;
        end
        x0pop_m = 1'b0;
        if (wb_if.alu_valid && wb_if.alu_rd != 0) begin
            we_m  = 1'b1;
            ad_m  = wb_if.alu_rd;
            wd_m  = wb_if.alu_data;
            src_m = 1'b0;
        end else if (fifo_m.size() > 0) begin
            h     = fifo_m.pop_front();
            src_m = 1'b1;
            if (h.rd != 0) begin
                we_m = 1'b1;
                ad_m = h.rd;
                wd_m = h.data;
            end else begin
                we_m    = 1'b0;
                x0pop_m = 1'b1;
            end
        end else begin
            we_m  = 1'b0;
            src_m = 1'b0;
        end
        if (accept) fifo_m.push_back('{rd: wb_if.lsu_rd, data: wb_if.lsu_data});
    endtask

    task automatic checkCycle();
        checkOutput("we3", wb_if.we3, we_m);
        if (we_m || !x0pop_m) begin
            checkOutput("ad3", wb_if.ad3, ad_m);
            checkOutput("wd3", wb_if.wd3, wd_m);
        end
        checkOutput("busy", wb_if.busy, busy_m);
        checkOutput("lsu_ready", wb_if.lsu_ready, !rst && (fifo_m.size() < DEPTH));
        checkOutput("stall", wb_if.stall, modelStall());
    endtask

    // Drive one cycle of inputs, check the pre-edge outputs, then advance the model and the DUT together
    task automatic applyStimulus(input logic r, input logic av, input logic [AW-1:0] ard,
                                 input logic [DW-1:0] adata, input logic lv, input logic [AW-1:0] lrd,
                                 input logic [DW-1:0] ldata, input logic iv, input logic [AW-1:0] ird,
                                 input logic [AW-1:0] s1, input logic [AW-1:0] s2);
        rst               = r;
        wb_if.alu_valid   = av;
        wb_if.alu_rd      = ard;
        wb_if.alu_data    = adata;
        wb_if.lsu_valid   = lv;
        wb_if.lsu_rd      = lrd;
        wb_if.lsu_data    = ldata;
        wb_if.issue_valid = iv;
        wb_if.issue_rd    = ird;
        wb_if.rs1         = s1;
        wb_if.rs2         = s2;
        #1;
        checkCycle();
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle(input logic [AW-1:0] s1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, 0);
    endtask

    int accepted;

    initial begin
        rst = 1'b1;
        wb_if.alu_valid = 0; wb_if.alu_rd = 0; wb_if.alu_data = 0;
        wb_if.lsu_valid = 0; wb_if.lsu_rd = 0; wb_if.lsu_data = 0;
        wb_if.issue_valid = 0; wb_if.issue_rd = 0; wb_if.rs1 = 0; wb_if.rs2 = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        modelReset();

        // Reset held for two cycles with an LSU offer present
        applyStimulus(1, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
        checkOutput("rst_ready", wb_if.lsu_ready, 1'b0);
        applyStimulus(1, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0);
        checkOutput("rst_we3", wb_if.we3, 1'b0);
        checkOutput("rst_busy", wb_if.busy, '0);
        rst = 1'b0;
        wb_if.lsu_valid = 1'b0;
        #1;
        checkOutput("post_rst_ready", wb_if.lsu_ready, 1'b1);
        idle(0);

        // ALU priority over a simultaneous LSU result
        applyStimulus(0, 1, 5, 32'h11, 1, 6, 32'h22, 0, 0, 0, 0);
        checkOutput("prio_c1_we3", wb_if.we3, 1'b1);
        checkOutput("prio_c1_ad3", wb_if.ad3, 5);
        checkOutput("prio_c1_wd3", wb_if.wd3, 32'h11);
        idle(0);
        checkOutput("prio_c2_we3", wb_if.we3, 1'b1);
        checkOutput("prio_c2_ad3", wb_if.ad3, 6);
        checkOutput("prio_c2_wd3", wb_if.wd3, 32'h22);
        idle(0);
        checkOutput("prio_c3_we3", wb_if.we3, 1'b0);

        // FIFO fills under sustained ALU traffic, then drains in order
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            logic took;
            took = (fifo_m.size() < DEPTH);
            applyStimulus(0, 1, 1, 32'hA0 + c, (accepted < 6) ? 1'b1 : 1'b0, AW'(10 + accepted),
                          32'h100 + accepted, 0, 0, 0, 0);
            if (took && accepted < 6) accepted++;
        end
        checkOutput("full_ready", wb_if.lsu_ready, 1'b0);
        checkOutput("full_accepts", accepted, DEPTH);
        idle(0);
        for (int k = 0; k < DEPTH; k++) begin
            checkOutput("drain_ad3", wb_if.ad3, 10 + k);
            checkOutput("drain_wd3", wb_if.wd3, 32'h100 + k);
            idle(0);
        end
        checkOutput("drain_ready", wb_if.lsu_ready, 1'b1);

        // x0 writes are never issued
        applyStimulus(0, 1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("x0_alu_we3", wb_if.we3, 1'b0);
        applyStimulus(0, 0, 0, 0, 1, 0, 32'h66, 0, 0, 0, 0);
        checkOutput("x0_lsu_we3_a", wb_if.we3, 1'b0);
        idle(0);
        checkOutput("x0_lsu_we3_b", wb_if.we3, 1'b0);
        checkOutput("x0_lsu_ready", wb_if.lsu_ready, 1'b1);
        idle(0);

        // RAW stall on x7 until its LSU write has been driven
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        checkOutput("raw_busy7", wb_if.busy[7], SB);
        applyStimulus(0, 0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 7, 0);
        checkOutput("raw_stall_a", wb_if.stall, SB);
        idle(7);
        checkOutput("raw_port_ad3", wb_if.ad3, 7);
        checkOutput("raw_port_wd3", wb_if.wd3, 32'hDEAD);
        checkOutput("raw_stall_b", wb_if.stall, SB);
        idle(7);
        checkOutput("raw_stall_clear", wb_if.stall, 1'b0);
        checkOutput("raw_busy7_clear", wb_if.busy[7], 1'b0);

        // Set wins over clear when an x3 issue meets an x3 LSU write on the port
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0);
        idle(0);
        checkOutput("coll_port_ad3", wb_if.ad3, 3);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        checkOutput("coll_busy3", wb_if.busy[3], SB);
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h34, 0, 0, 0, 0);
        idle(0);
        idle(0);
        checkOutput("coll_busy3_clear", wb_if.busy[3], 1'b0);

        // Random traffic with occasional reset
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 1) == 1), AW'($urandom_range(0, NREG - 1)), $urandom(),
                          ($urandom_range(0, 2) != 0), AW'($urandom_range(0, NREG - 1)), $urandom(),
                          ($urandom_range(0, 3) == 0), AW'($urandom_range(0, NREG - 1)),
                          AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-side front end for the 32x32 register file. It merges two result streams into the file's single write port (`ad3`/`we3`/`wd3`):
- single-cycle ALU results, which have absolute priority;
- long-latency LSU results, which are handshaked and buffered in a small FIFO.

It also keeps a pending-write scoreboard so decode can stall on registers whose LSU result has not yet been committed. It sits between execute/memory and the register file, on the opposite side of the port from the decode-stage readers.

## Interface
Parameters:
- `Data_width`, 32, result/data width
- `Addr_width`, 5, register index width (2**Addr_width registers)
- `Fifo_depth`, 4, LSU result FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock; everything updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  Addr_width  ALU destination register
- `alu_data`  in  Data_width  ALU result
- `lsu_valid`  in  1  LSU result offered
- `lsu_ready`  out  1  FIFO can accept an LSU result
- `lsu_rd`  in  Addr_width  LSU destination register
- `lsu_data`  in  Data_width  LSU result
- `issue_valid`  in  1  decode issues a long-latency op this cycle
- `issue_rd`  in  Addr_width  its destination register
- `rs1`, `rs2`  in  Addr_width  source registers of the instruction in decode
- `stall`  out  1  decode must hold
- `busy`  out  2**Addr_width  pending-write bit vector
- `we3`  out  1  register-file write enable (registered)
- `ad3`  out  Addr_width  register-file write address (registered)
- `wd3`  out  Data_width  register-file write data (registered)

## Operation
- **Reset values:** `we3`=0, `ad3`=0, `wd3`=0, `busy`=0, FIFO empty.
  - `lsu_ready`=0 while `rst`=1.
  - `lsu_ready`=1 in the first cycle after reset.
- **Arbitration** (evaluated each cycle, result registered onto `we3`/`ad3`/`wd3`):
  - If `alu_valid` and `alu_rd`≠0: drive the ALU write. The FIFO is not popped.
  - Else if the FIFO is non-empty: pop the head and drive its write. Mark the output as LSU-sourced (internal flag).
  - Else: `we3`=0; `ad3` and `wd3` hold their previous values.
- **x0 handling:** writes to x0 are never issued.
  - An ALU result with rd=0 is discarded.
  - An LSU result with rd=0 is accepted but, when popped, produces `we3`=0. The pop slot is still consumed.
- **FIFO:**
  - `lsu_ready` = !full. Full is evaluated before this cycle's pop, so nothing is accepted when full, even if a pop occurs in the same cycle.
  - Push on `lsu_valid`&&`lsu_ready`.
  - Order is strict FIFO.
  - Pointers wrap modulo `Fifo_depth`. Use an occupancy counter of width log2(`Fifo_depth`)+1.
- **Scoreboard:**
  - Set: `busy[issue_rd]` is set on `issue_valid`&&!`stall`&&`issue_rd`≠0.
  - Clear: `busy[r]` is cleared at the edge ending a cycle in which `we3`=1, `ad3`=r and the output is LSU-sourced.
  - Set and clear of the same register in the same cycle: set wins.
  - `stall` = `busy[rs1]` | `busy[rs2]` | (`issue_valid` & `busy[issue_rd]`). This covers RAW and WAW. Index 0 is never busy.
- ALU results never clear `busy`. The issue logic guarantees that no ALU op targets a busy register, because it stalls.
- **Reset mid-operation:** the FIFO is flushed, `busy` is cleared, and any in-flight `we3` is dropped on the reset edge.

## Timing
- **ALU path:** result presented in cycle N → `we3`/`ad3`/`wd3` valid in cycle N+1 → register file captures at the end of N+1.
- **LSU path:** accepted in cycle N → head of the FIFO in N+1 → on the write port in N+2 at the earliest. Each cycle with an ALU write adds one cycle of delay.
- **busy / stall:** `busy` clears at the end of the LSU write cycle. `stall` therefore deasserts the cycle after the write is driven, which is the first cycle in which the asynchronous regfile read returns the new value.
- **Throughput:** one write per cycle.
- **Starvation:** sustained ALU traffic starves the FIFO. It fills, `lsu_ready` drops, and the LSU must hold its offer stable until accepted.
- `stall` and `lsu_ready` are combinational from registered state plus current inputs. No input-to-output path exists through `we3`/`ad3`/`wd3`.

## Configuration
- `WB_SCOREBOARD_EN`
  - **Defined:** the scoreboard is built as described above.
  - **Undefined:** no scoreboard storage. `busy` is tied to 0 and `stall` to 0. The `issue_*`, `rs1` and `rs2` inputs are ignored.
  - The arbitration, FIFO and write-port behaviour are identical in both builds.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `lsu_valid`=1 → `we3`=0, `busy`=0, `lsu_ready`=0. First cycle after reset → `lsu_ready`=1.
- **ALU priority:** `alu_valid`=1, rd=5, data=0x11 and `lsu_valid`=1, rd=6, data=0x22 in cycle 0, then idle.
  - Cycle 1: `we3`=1, `ad3`=5, `wd3`=0x11.
  - Cycle 2: `we3`=1, `ad3`=6, `wd3`=0x22.
- **FIFO full:** hold `alu_valid`=1 (rd=1) and offer 6 LSU results.
  - After 4 accepts, `lsu_ready`=0.
  - Drop the ALU → the 4 entries drain in order on consecutive cycles, and `lsu_ready` returns to 1.
- **x0 discard:**
  - ALU with rd=0 → `we3` stays 0.
  - LSU with rd=0 → accepted, popped with `we3`=0, occupancy returns to 0.
- **Scoreboard RAW:** issue rd=7 → `busy[7]`=1. `rs1`=7 → `stall`=1 until the LSU write to x7 (0xDEAD) is driven; `stall`=0 in the following cycle.
- **Set/clear collision:** an LSU write to x3 is on the port in the same cycle as a new issue with rd=3 → `busy[3]` remains 1.
